bus_sequencer: RTL and testbench

Micro-operation sequencer for the shared 8-bit data bus, 16-bit address bus, eight-register file and memory. It accepts one command at a time over a valid/ready handshake and drives the per-register one-hot enables (`regs_rdata`, `regs_wdata`, `regs_raddr`, `regs_waddr`) and the memory controls (`mem_ce`, `mem_wre`, `mem_rst`). It guarantees that at most one agent drives the data bus in any cycle. It sits between instruction decode and the datapath, replacing hand-driven enables.

---
 rtl/scpu_pkg.sv | 40 ++++
 rtl/bus_sequencer_if.sv | 33 +++
 rtl/onehot_dec3.sv | 18 +
 rtl/bus_sequencer.sv | 160 ++++++++++++++++
 tb/tb_bus_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scpu_pkg.sv
// Shared definitions for the bus sequencer: op and state encodings, the
// captured command record and the address-pair to register mapping.
package scpu_pkg;

  localparam int NREGS = 8;

  typedef enum logic [1:0] {
    OP_MOV   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_MRST  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOV     = 3'd1,
    ST_ST      = 3'd2,
    ST_MRST    = 3'd3,
    ST_LD_ADDR = 3'd4,
    ST_LD_WAIT = 3'd5,
    ST_LD_DATA = 3'd6
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [2:0] src;
    logic [2:0] dst;
    logic [1:0] pair;
  } cmd_t;

  // Pair p: register 2p drives addr_bus[15:8], register 2p+1 drives addr_bus[7:0].
  function automatic logic [2:0] pair_hi_reg(input logic [1:0] pair);
    return {pair, 1'b0};
  endfunction

  function automatic logic [2:0] pair_lo_reg(input logic [1:0] pair);
    return {pair, 1'b1};
  endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// Command handshake plus register-file / memory enable bundle.
// master = instruction decode / datapath side, slave = the sequencer.
interface bus_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_src;
  logic [2:0] cmd_dst;
  logic [1:0] cmd_pair;
  logic       done;
  logic       busy;
  logic [7:0] regs_rdata;
  logic [7:0] regs_wdata;
  logic [7:0] regs_raddr;
  logic [7:0] regs_waddr;
  logic       mem_ce;
  logic       mem_wre;
  logic       mem_rst;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_pair,
    input  cmd_ready, done, busy, regs_rdata, regs_wdata, regs_raddr,
    input  regs_waddr, mem_ce, mem_wre, mem_rst
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_pair,
    output cmd_ready, done, busy, regs_rdata, regs_wdata, regs_raddr,
    output regs_waddr, mem_ce, mem_wre, mem_rst
  );

endinterface

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot decoder with enable; all zeros when disabled.
module onehot_dec3 (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  // Decode index into a single set bit.
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = 8'h00;
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// Micro-op sequencer: captures one command, then steps the register-file and
// memory enables so that at most one agent drives the data bus per cycle.
module bus_sequencer
  import scpu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  bus_sequencer_if.slave  bus
);

  localparam logic [1:0] WAIT_LAST = 2'(MEM_RD_LAT - 2);

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [1:0] wait_q, wait_d;

  logic       rd_en_s, wr_en_s, pair_en_s;
  logic       ce_d, wre_d, mrst_d, done_d, busy_d, ready_d;
  logic [7:0] rdata_d, wdata_d, pair_hi_s, raddr_d;
  logic       ce_q, wre_q, mrst_q, done_q, busy_q, ready_q;
  logic [7:0] rdata_q, wdata_q, raddr_q;

  // State, captured command and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '{op: OP_MOV, src: 3'd0, dst: 3'd0, pair: 2'd0};
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      wait_q  <= wait_d;
    end
  end

  // Next state; fields are captured only on the accepting edge.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d.op   = op_e'(bus.cmd_op);
          cmd_d.src  = bus.cmd_src;
          cmd_d.dst  = bus.cmd_dst;
          cmd_d.pair = bus.cmd_pair;
          wait_d     = 2'd0;
          case (op_e'(bus.cmd_op))
            OP_MOV:   state_d = ST_MOV;
            OP_LOAD:  state_d = ST_LD_ADDR;
            OP_STORE: state_d = ST_ST;
            OP_MRST:  state_d = ST_MRST;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LD_ADDR: begin
        if (MEM_RD_LAT == 1) begin
          state_d = ST_LD_DATA;
        end else begin
          state_d = ST_LD_WAIT;
        end
      end
      ST_LD_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_LD_DATA;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_MOV, ST_ST, ST_MRST, ST_LD_DATA: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Enables for the upcoming cycle, decoded from next state and fields.
  always_comb begin
    rd_en_s   = 1'b0;
    wr_en_s   = 1'b0;
    pair_en_s = 1'b0;
    ce_d      = 1'b0;
    wre_d     = 1'b0;
    mrst_d    = 1'b0;
    case (state_d)
      ST_MOV: begin
        rd_en_s = 1'b1;
        wr_en_s = 1'b1;
      end
      ST_ST: begin
        pair_en_s = 1'b1;
        rd_en_s   = 1'b1;
        ce_d      = 1'b1;
        wre_d     = 1'b1;
      end
      ST_MRST: mrst_d = 1'b1;
      ST_LD_ADDR, ST_LD_WAIT: begin
        pair_en_s = 1'b1;
        ce_d      = 1'b1;
      end
      ST_LD_DATA: begin
        pair_en_s = 1'b1;
        ce_d      = 1'b1;
        wr_en_s   = 1'b1;
      end
      default: begin
        rd_en_s = 1'b0;
      end
    endcase
    raddr_d = pair_hi_s | (pair_hi_s << 1);
    done_d  = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  onehot_dec3 u_rd_dec   (.en(rd_en_s),   .idx(cmd_d.src),              .onehot(rdata_d));
  onehot_dec3 u_wr_dec   (.en(wr_en_s),   .idx(cmd_d.dst),              .onehot(wdata_d));
  onehot_dec3 u_pair_dec (.en(pair_en_s), .idx(pair_hi_reg(cmd_d.pair)), .onehot(pair_hi_s));

  // Output registers; reset drops any command in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 8'h00;
      wdata_q <= 8'h00;
      raddr_q <= 8'h00;
      ce_q    <= 1'b0;
      wre_q   <= 1'b0;
      mrst_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      ce_q    <= ce_d;
      wre_q   <= wre_d;
      mrst_q  <= mrst_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.regs_rdata = rdata_q;
  assign bus.regs_wdata = wdata_q;
  assign bus.regs_raddr = raddr_q;
  assign bus.regs_waddr = 8'h00;
  assign bus.mem_ce     = ce_q;
  assign bus.mem_wre    = wre_q;
  assign bus.mem_rst    = mrst_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.cmd_ready  = ready_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench: stimulus pushes expected per-cycle enables and completion
// records; a negedge monitor pops and compares against a register/memory model.
module tb_bus_sequencer;
  import scpu_pkg::*;

  localparam int LAT = 3;
  localparam logic [7:0] RF_INIT [8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                                         8'h55, 8'h66, 8'h77, 8'h88};

  typedef struct {
    int         cyc;
    logic [7:0] rdata, wdata, raddr;
    logic       ce, wre, mrst;
  } trace_t;

  typedef struct {
    int          cyc;
    logic [63:0] regs;
    bit          chk_mem;
    logic [15:0] addr;
    logic [7:0]  val;
  } done_t;

  logic clk = 1'b0;
  logic rst;
  logic load_rf;
  bit   mon_en = 1'b0;
  bit   sb_off = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_sequencer_if bus ();
  bus_sequencer #(.MEM_RD_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Datapath model driven by the DUT enables
  logic [7:0]  rf [8];
  logic [7:0]  mem_d [65536];
  int unsigned mem_tag [65536];
  int unsigned gen = 0;
  logic        pipe_v [LAT];
  logic [7:0]  pipe_d [LAT];
  logic [7:0]  data_bus;
  logic [15:0] addr_bus;
  int          n_drv;

  always_comb begin
    data_bus = 8'h00;
    addr_bus = 16'h0000;
    n_drv    = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.regs_rdata[i]) begin
        data_bus = rf[i];
        n_drv    = n_drv + 1;
      end
      if (bus.regs_raddr[i]) begin
        if (i % 2 == 0) addr_bus[15:8] = addr_bus[15:8] | rf[i];
        else            addr_bus[7:0]  = addr_bus[7:0] | rf[i];
      end
    end
    if (pipe_v[LAT-1] && bus.mem_ce && !bus.mem_wre) begin
      data_bus = pipe_d[LAT-1];
      n_drv    = n_drv + 1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 8; i++) begin
      if (load_rf) rf[i] <= RF_INIT[i];
      else if (bus.regs_wdata[i]) rf[i] <= data_bus;
    end
    if (bus.mem_ce && bus.mem_wre) begin
      mem_d[addr_bus]   <= data_bus;
      mem_tag[addr_bus] <= gen;
    end
    if (load_rf) gen <= 1;
    else if (bus.mem_rst) gen <= gen + 1;
    pipe_v[0] <= bus.mem_ce && !bus.mem_wre && !rst;
    pipe_d[0] <= (mem_tag[addr_bus] == gen) ? mem_d[addr_bus] : 8'h00;
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1] && !rst;
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  // Architectural reference and scoreboard queues
  logic [7:0] ref_rf [8];
  logic [7:0] ref_mem [int];
  trace_t     tq [$];
  done_t      dq [$];

  function automatic logic [63:0] pack_ref();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_rf[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_rf();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = rf[i];
    return v;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return (mem_tag[a] == gen) ? mem_d[a] : 8'h00;
  endfunction

  task automatic send(input logic [1:0] op, input logic [2:0] src,
                      input logic [2:0] dst, input logic [1:0] pair, input bit track);
    int          e;
    int          n;
    logic [15:0] a;
    trace_t      t;
    done_t       d;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_pair  = pair;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
      bus.cmd_valid = 1'b0;
      return;
    end
    e = cyc + 1;
    if (track) begin
      a = {ref_rf[{pair, 1'b0}], ref_rf[{pair, 1'b1}]};
      t.cyc = e; t.rdata = 8'h00; t.wdata = 8'h00; t.raddr = 8'h00;
      t.ce = 1'b0; t.wre = 1'b0; t.mrst = 1'b0;
      d.chk_mem = 1'b0; d.addr = a; d.val = 8'h00;
      n = 1;
      case (op)
        2'b00: begin
          t.rdata = 8'h01 << src;
          t.wdata = 8'h01 << dst;
          tq.push_back(t);
          ref_rf[dst] = ref_rf[src];
        end
        2'b10: begin
          t.rdata = 8'h01 << src;
          t.raddr = 8'h03 << {pair, 1'b0};
          t.ce = 1'b1; t.wre = 1'b1;
          tq.push_back(t);
          ref_mem[int'(a)] = ref_rf[src];
          d.chk_mem = 1'b1;
          d.val = ref_rf[src];
        end
        2'b11: begin
          t.mrst = 1'b1;
          tq.push_back(t);
          ref_mem.delete();
        end
        default: begin
          for (int k = 0; k <= LAT; k++) begin
            t.cyc   = e + k;
            t.raddr = 8'h03 << {pair, 1'b0};
            t.ce    = 1'b1;
            t.wdata = (k == LAT) ? (8'h01 << dst) : 8'h00;
            tq.push_back(t);
          end
          ref_rf[dst] = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
          n = LAT + 1;
        end
      endcase
      d.cyc  = e + n;
      d.regs = pack_ref();
      dq.push_back(d);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom_range(0, 3));
    bus.cmd_src   = 3'($urandom_range(0, 7));
    bus.cmd_dst   = 3'($urandom_range(0, 7));
    bus.cmd_pair  = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int n = 0;
    while ((bus.busy || tq.size() != 0 || dq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.regs_rdata !== 8'h00 || bus.regs_wdata !== 8'h00 || bus.regs_raddr !== 8'h00 ||
        bus.regs_waddr !== 8'h00 || bus.mem_ce !== 1'b0 || bus.mem_wre !== 1'b0 ||
        bus.mem_rst !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b busy=%b done=%b rd=%h wd=%h ra=%h wa=%h ce=%b wre=%b mrst=%b, required ready=1 and all else 0",
               name, bus.cmd_ready, bus.busy, bus.done, bus.regs_rdata, bus.regs_wdata,
               bus.regs_raddr, bus.regs_waddr, bus.mem_ce, bus.mem_wre, bus.mem_rst);
    end
  endtask

  // Monitor: invariants every cycle, trace on busy cycles, completion on done
  trace_t mt;
  done_t  md;
  logic   inv_ok;

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      checks++;
      inv_ok = ($countones(bus.regs_rdata) <= 1) && ($countones(bus.regs_wdata) <= 1) &&
               (bus.regs_waddr == 8'h00) && !(bus.mem_ce && !bus.mem_wre && bus.regs_rdata != 8'h00) &&
               (n_drv <= 1) && (bus.cmd_ready == !bus.busy) &&
               (bus.busy || (bus.regs_rdata == 8'h00 && bus.regs_wdata == 8'h00 &&
                bus.regs_raddr == 8'h00 && !bus.mem_ce && !bus.mem_wre && !bus.mem_rst));
      if (!inv_ok) begin
        errors++;
        $display("FAIL invariant cyc=%0d: rd=%h wd=%h ra=%h wa=%h ce=%b wre=%b mrst=%b ready=%b busy=%b drivers=%0d, required onehot enables, single driver, ready==!busy, idle enables 0",
                 cyc, bus.regs_rdata, bus.regs_wdata, bus.regs_raddr, bus.regs_waddr,
                 bus.mem_ce, bus.mem_wre, bus.mem_rst, bus.cmd_ready, bus.busy, n_drv);
      end
      if (bus.busy && !sb_off) begin
        checks++;
        if (tq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_busy cyc=%0d: busy=1, required 0", cyc);
        end else begin
          mt = tq.pop_front();
          if (cyc != mt.cyc || bus.regs_rdata !== mt.rdata || bus.regs_wdata !== mt.wdata ||
              bus.regs_raddr !== mt.raddr || bus.mem_ce !== mt.ce || bus.mem_wre !== mt.wre ||
              bus.mem_rst !== mt.mrst) begin
            errors++;
            $display("FAIL exec_cycle: got cyc=%0d rd=%h wd=%h ra=%h ce=%b wre=%b mrst=%b, required cyc=%0d rd=%h wd=%h ra=%h ce=%b wre=%b mrst=%b",
                     cyc, bus.regs_rdata, bus.regs_wdata, bus.regs_raddr, bus.mem_ce, bus.mem_wre,
                     bus.mem_rst, mt.cyc, mt.rdata, mt.wdata, mt.raddr, mt.ce, mt.wre, mt.mrst);
          end
        end
      end
      if (bus.done) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d: done=1, required 0", cyc);
        end else begin
          md = dq.pop_front();
          if (cyc != md.cyc || pack_rf() !== md.regs ||
              (md.chk_mem && mem_rd(md.addr) !== md.val)) begin
            errors++;
            $display("FAIL done_result: got cyc=%0d regs=%h mem[%h]=%h, required cyc=%0d regs=%h mem=%h (checked=%b)",
                     cyc, pack_rf(), md.addr, mem_rd(md.addr), md.cyc, md.regs, md.val, md.chk_mem);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    load_rf = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00; bus.cmd_src = 3'd0; bus.cmd_dst = 3'd0; bus.cmd_pair = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    load_rf = 1'b0;
    ref_rf = RF_INIT;
    @(negedge clk);
    check_idle("reset_state");
    mon_en = 1'b1;

    send(2'b00, 3'd3, 3'd6, 2'd0, 1'b1);   // MOV r3->r6
    send(2'b10, 3'd1, 3'd0, 2'd2, 1'b1);   // STORE r1 -> [r4:r5]
    repeat (2) @(negedge clk);
    send(2'b10, 3'd7, 3'd0, 2'd0, 1'b1);   // STORE r7 -> [r0:r1]
    send(2'b01, 3'd0, 3'd0, 2'd0, 1'b1);   // LOAD r0 <- [r0:r1], dst in pair
    send(2'b00, 3'd2, 3'd5, 2'd0, 1'b1);   // back-to-back MOV, STORE, MRST
    send(2'b10, 3'd0, 3'd0, 2'd1, 1'b1);
    send(2'b11, 3'd0, 3'd0, 2'd0, 1'b1);
    repeat (2) @(negedge clk);
    send(2'b00, 3'd4, 3'd4, 2'd0, 1'b1);   // src == dst
    send(2'b10, 3'd3, 3'd0, 2'd1, 1'b1);   // src inside pair
    send(2'b01, 3'd0, 3'd2, 2'd1, 1'b1);   // dst inside pair

    drain();
    sb_off = 1'b1;
    send(2'b01, 3'd0, 3'd7, 2'd1, 1'b0);   // LOAD aborted by reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_mid_load");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (rf[7] !== ref_rf[7]) begin
      errors++;
      $display("FAIL reset_dst_kept: r7=%h, required %h", rf[7], ref_rf[7]);
    end
    sb_off = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    drain();
    checks++;
    if (tq.size() != 0 || dq.size() != 0 || pack_rf() !== pack_ref()) begin
      errors++;
      $display("FAIL final_state: pending trace=%0d done=%0d regs=%h, required 0 0 %h",
               tq.size(), dq.size(), pack_rf(), pack_ref());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
